// File: rtl/sqr_pkg.sv
// Shared types and helpers for the iterative squarer.
package sqr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned SQR_W_DEFAULT = 6;

  // Step-counter width; it has to index bits 0..W-1 of the multiplier.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sqr_abs.sv
// Conditional magnitude of a W-bit operand; the only place signed data is interpreted.
module sqr_abs
  import sqr_pkg::*;
#(
  parameter int unsigned W = SQR_W_DEFAULT
) (
  input  logic [W-1:0] data_i,
  input  logic         signed_i,
  output logic [W-1:0] abs_c_o
);

  logic neg_c;

  // -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1).
  assign neg_c   = signed_i & data_i[W-1];
  assign abs_c_o = neg_c ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/sqr_iter.sv
// Iterative W-bit squarer: one shift-add step per cycle, valid/ready on both sides.
module sqr_iter
  import sqr_pkg::*;
#(
  parameter int unsigned W = SQR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_data,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(W);
  localparam int unsigned AW = 2 * W;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    m_q, m_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    abs_c;
  logic [AW-1:0]   step_c;
  logic [AW-1:0]   acc_step_c;
  logic            last_c;

  sqr_abs #(.W(W)) u_abs (
    .data_i   (in_data),
    .signed_i (in_signed),
    .abs_c_o  (abs_c)
  );

  // Partial product for the current multiplier bit.
  assign step_c     = m_q[cnt_q] ? (AW'(a_q) << cnt_q) : '0;
  assign acc_step_c = acc_q + step_c;
  assign last_c     = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    m_d        = m_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = BUSY;
          a_d     = abs_c;
          m_d     = abs_c;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CW'(1);
        if (last_c) begin
          state_d    = DONE;
          out_data_d = acc_step_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are decodes of the next state so they stay registered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sqr_iter.sv
// Bench for sqr_iter: directed W=6 scenarios plus W=4 / W=12 scoreboarded sweeps.
module tb_sqr_iter;

  logic clk;
  logic rst_n;

  logic        v6, r6, s6, ov6, or6, b6;
  logic [5:0]  d6;
  logic [11:0] od6;

  logic        v4, r4, s4, ov4, or4, b4;
  logic [3:0]  d4;
  logic [7:0]  od4;

  logic        v12, r12, s12, ov12, or12, b12;
  logic [11:0] d12;
  logic [23:0] od12;

  int n_checks;
  int n_fail;
  int n_out12;
  bit rand_or;

  logic [63:0] q6[$];
  logic [63:0] q4[$];
  logic [63:0] q12[$];

  sqr_iter #(.W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_data(d6),
    .in_signed(s6), .out_valid(ov6), .out_ready(or6), .out_data(od6), .busy(b6)
  );

  sqr_iter #(.W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .in_signed(s4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(b4)
  );

  sqr_iter #(.W(12)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(r12), .in_data(d12),
    .in_signed(s12), .out_valid(ov12), .out_ready(or12), .out_data(od12), .busy(b12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference square of a w-bit operand, interpreted signed or unsigned.
  function automatic logic [63:0] sq_ref(input int w, input logic [31:0] x, input logic s);
    logic [63:0] mag;
    mag = {32'b0, x};
    if (s && x[w-1]) mag = (64'd1 << w) - mag;
    return mag * mag;
  endfunction

  function automatic logic ready_of(input int unit);
    case (unit)
      4:       return r4;
      12:      return r12;
      default: return r6;
    endcase
  endfunction

  // One clock: sample handshakes at negedge, score them, resume at posedge + 1.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (v6 && r6)   q6.push_back(sq_ref(6, 32'(d6), s6));
    if (v4 && r4)   q4.push_back(sq_ref(4, 32'(d4), s4));
    if (v12 && r12) q12.push_back(sq_ref(12, 32'(d12), s12));
    if (ov6 && or6) begin
      n_checks++;
      if (q6.size() == 0) begin
        n_fail++; $display("FAIL sb6_unmatched: result %0d with no pending operand", od6);
      end else begin
        e = q6.pop_front();
        if ({52'b0, od6} !== e) begin
          n_fail++; $display("FAIL sb6_result: got %0d expected %0d", od6, e);
        end
      end
    end
    if (ov4 && or4) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_fail++; $display("FAIL sb4_unmatched: result %0d with no pending operand", od4);
      end else begin
        e = q4.pop_front();
        if ({56'b0, od4} !== e) begin
          n_fail++; $display("FAIL sb4_result: got %0d expected %0d", od4, e);
        end
      end
    end
    if (ov12 && or12) begin
      n_checks++;
      n_out12++;
      if (q12.size() == 0) begin
        n_fail++; $display("FAIL sb12_unmatched: result %0d with no pending operand", od12);
      end else begin
        e = q12.pop_front();
        if ({40'b0, od12} !== e) begin
          n_fail++; $display("FAIL sb12_result: got %0d expected %0d", od12, e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_or) begin
      or4  = 1'($urandom_range(0, 1));
      or12 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input int unit, input logic [31:0] x, input logic s);
    int i;
    i = 0;
    while (!ready_of(unit) && i < 200) begin
      tick();
      i++;
    end
    if (!ready_of(unit)) begin
      n_checks++; n_fail++;
      $display("FAIL send%0d_timeout: in_ready=%b required 1", unit, ready_of(unit));
    end
    case (unit)
      4:       begin v4 = 1'b1;  d4 = x[3:0];   s4 = s;  end
      12:      begin v12 = 1'b1; d12 = x[11:0]; s12 = s; end
      default: begin v6 = 1'b1;  d6 = x[5:0];   s6 = s;  end
    endcase
    tick();
    v4 = 1'b0; v6 = 1'b0; v12 = 1'b0;
  endtask

  task automatic wait_ov6();
    int i;
    i = 0;
    while (!ov6 && i < 100) begin
      tick();
      i++;
    end
    if (!ov6) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ov6_timeout: out_valid=%b required 1", ov6);
    end
  endtask

  task automatic check6(input logic [5:0] x, input logic s, input logic [11:0] exp_sq);
    send(6, 32'(x), s);
    wait_ov6();
    n_checks++;
    if (od6 !== exp_sq) begin
      n_fail++; $display("FAIL square6 x=%b s=%b: got %0d expected %0d", x, s, od6, exp_sq);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    v6 = 0; v4 = 0; v12 = 0; s6 = 0; s4 = 0; s12 = 0;
    d6 = '0; d4 = '0; d12 = '0;
    or6 = 0; or4 = 0; or12 = 0;
    rand_or = 0;
    #1 rst_n = 1'b0;
    #11;
    n_checks++;
    if ({ov6, r6, b6, od6} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 12'd0}) begin
      n_fail++; $display("FAIL reset6: ov/rdy/busy/data=%b/%b/%b/%0d expected 0/1/0/0", ov6, r6, b6, od6);
    end
    n_checks++;
    if ({ov12, r12, b12, od12} !== {1'b0, 1'b1, 1'b0, 24'd0}) begin
      n_fail++; $display("FAIL reset12: ov/rdy/busy/data=%b/%b/%b/%0d expected 0/1/0/0", ov12, r12, b12, od12);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    or6 = 1'b1;
    send(6, 32'h3F, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (b6 !== 1'b1) begin
        n_fail++; $display("FAIL lat_busy k=%0d: busy=%b expected 1", k, b6);
      end
      if (k == 5) begin
        n_checks++;
        if (ov6 !== 1'b0) begin
          n_fail++; $display("FAIL lat_early: out_valid=%b expected 0 after %0d edges", ov6, k);
        end
      end
    end
    n_checks++;
    if ({ov6, od6} !== {1'b1, 12'hF81}) begin
      n_fail++; $display("FAIL lat_result: ov=%b data=%h expected 1 / f81", ov6, od6);
    end
    tick();
    n_checks++;
    if ({ov6, r6, b6} !== 3'b010) begin
      n_fail++; $display("FAIL lat_release: ov/rdy/busy=%b%b%b expected 010", ov6, r6, b6);
    end
  endtask

  task automatic test_values();
    logic [5:0]  xs[4];
    logic        ss[4];
    logic [11:0] es[4];
    xs = '{6'b111011, 6'b111011, 6'b100000, 6'd0};
    ss = '{1'b0, 1'b1, 1'b1, 1'b0};
    es = '{12'd3481, 12'd25, 12'd1024, 12'd0};
    or6 = 1'b1;
    for (int i = 0; i < 4; i++) check6(xs[i], ss[i], es[i]);
  endtask

  task automatic test_backpressure();
    or6 = 1'b0;
    send(6, 32'd45, 1'b0);
    wait_ov6();
    for (int i = 0; i < 10; i++) begin
      v6 = 1'b1;
      d6 = 6'($urandom_range(0, 63));
      s6 = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({ov6, r6, b6, od6} !== {1'b1, 1'b0, 1'b1, 12'd2025}) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d: ov/rdy/busy/data=%b/%b/%b/%0d expected 1/0/1/2025", i, ov6, r6, b6, od6);
      end
    end
    v6 = 1'b0;
    or6 = 1'b1;
    tick();
    n_checks++;
    if ({ov6, r6, b6} !== 3'b010) begin
      n_fail++; $display("FAIL bp_release: ov/rdy/busy=%b%b%b expected 010", ov6, r6, b6);
    end
    or6 = 1'b0;
    tick();
    n_checks++;
    if ({ov6, r6, 32'(q6.size())} !== {1'b0, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL bp_single: ov=%b rdy=%b pending=%0d expected 0/1/0", ov6, r6, q6.size());
    end
  endtask

  task automatic test_reset_midbusy();
    or6 = 1'b1;
    send(6, 32'd50, 1'b0);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov6, r6, b6, od6} !== {1'b0, 1'b1, 1'b0, 12'd0}) begin
      n_fail++; $display("FAIL rst_mid: ov/rdy/busy/data=%b/%b/%b/%0d expected 0/1/0/0", ov6, r6, b6, od6);
    end
    q6.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (ov6 !== 1'b0) begin
        n_fail++; $display("FAIL rst_ghost cyc=%0d: out_valid=%b expected 0", i, ov6);
      end
    end
    check6(6'd7, 1'b0, 12'd49);
  endtask

  task automatic drain();
    int i;
    rand_or = 0;
    or4 = 1'b1;
    or12 = 1'b1;
    i = 0;
    while ((q4.size() != 0 || q12.size() != 0) && i < 100) begin
      tick();
      i++;
    end
  endtask

  task automatic test_sweep4();
    rand_or = 1;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++) send(4, 32'(x), 1'(s));
    drain();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++; $display("FAIL sweep4_pending: %0d results missing, expected 0", q4.size());
    end
  endtask

  task automatic test_sweep12();
    n_out12 = 0;
    rand_or = 1;
    repeat (2000) send(12, 32'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    drain();
    n_checks++;
    if (q12.size() != 0 || n_out12 != 2000) begin
      n_fail++; $display("FAIL sweep12_count: outputs=%0d pending=%0d expected 2000/0", n_out12, q12.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_out12  = 0;
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_reset_midbusy();
    test_sweep4();
    test_sweep12();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqr_iter.md
# sqr_iter

Parametrised iterative squarer: accepts a W-bit operand over a valid/ready handshake and returns the full 2W-bit square. The operand is either unsigned or two's complement, chosen per transaction. It is the sequential, width-generic successor to the flat single-output-bit square logic produced from PLA benchmarks. It trades area for latency with one shift-add step per cycle and sits between an operand producer and a result consumer, both of which may stall.

## Interface
- W, default 6: operand width in bits; legal range 2..32.
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- in_data  in  W  operand.
- in_signed  in  1  1 means in_data is two's complement; sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  2W  square, unsigned.
- busy  out  1  high in BUSY or DONE.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, register a=|in_data| (absolute value only when in_signed=1, else raw), m=a, acc=0, cnt=0, then go to BUSY.
- **BUSY:** one step per cycle.
  - If m[cnt], then acc += a<<cnt. cnt++.
  - After the step with cnt=W-1, go to DONE, with out_data=acc.
- **DONE:**
  - out_valid=1; out_data is held stable.
  - On out_valid&out_ready, go to IDLE.
  - No new operand is accepted in DONE, including in the handshake cycle.
- **Width rules:**
  - |x| is a W-bit unsigned value. The signed −2^(W−1) maps to 2^(W−1) with no overflow.
  - acc is 2W bits; the maximum (2^W−1)^2 < 2^(2W), so there is no truncation.
- **Input side:** in_data, in_signed and in_valid are ignored outside IDLE.
- **Output side:** out_ready is ignored outside DONE.
- **Reset, async, any state:**
  - state=IDLE; acc, a, m, cnt = 0.
  - out_valid=0, out_data=0, busy=0, in_ready=1.
  - An in-flight operation is discarded, with no partial output.

## Timing
- An operand accepted at edge t puts the block in BUSY for the W edges t+1..t+W.
- out_valid rises after edge t+W; latency is W+1 cycles when out_ready is already high.
- The result handshake at edge t+W+1 returns the block to IDLE. The earliest next accept is edge t+W+2, so throughput is one result per W+2 cycles.
- in_ready is a registered-state decode (state==IDLE); there is no combinational path from out_ready or in_valid.
- out_data changes only on the BUSY→DONE transition or at reset.

## Structure
- **Package sqr_pkg:**
  - state enum (IDLE, BUSY, DONE).
  - SQR_W_DEFAULT=6.
  - Function for the width of cnt, clog2(W).
- **Sub-module sqr_abs:** combinational, W-bit conditional two's-complement negate on (signed & msb). It holds the only signed logic.
- **Top level:** FSM, datapath registers and handshake.

## Test plan
- W=6, unsigned 6'h3F, out_ready=1 → out_data=12'hF81 (3969), out_valid after exactly 7 cycles from the accept.
- W=6, 6'b111011: with in_signed=0 → 3481; with in_signed=1 → 25.
- W=6, signed 6'b100000 (−32) → 1024; unsigned 0 → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0, in_valid pulses ignored. Raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Assert rst_n low mid-BUSY (cnt=3) → outputs are at reset values immediately, with no out_valid afterwards. A new operand 7 returns 49.
- Random sweep: W=4 exhaustive over both signed modes, and W=12 with 2000 random operands and random out_ready → every result matches the reference square, and every output handshake is matched one-to-one with an input handshake.
